// File: rtl/bp_mcore_looper_if.sv
// Config and chunk-request channels of the hardware looper.
// slave: device side; master: network / core side.
interface bp_mcore_looper_if #(
  parameter int num_core_p    = 4,
  parameter int index_width_p = 64
) ();
  localparam int id_w = (num_core_p > 1) ? $clog2(num_core_p) : 1;

  logic                     cfg_v_i;
  logic                     cfg_w_i;
  logic [19:0]              cfg_addr_i;
  logic [63:0]              cfg_data_i;
  logic                     cfg_ready_o;
  logic                     cfg_v_o;
  logic [63:0]              cfg_data_o;
  logic                     cfg_yumi_i;

  logic                     req_v_i;
  logic [id_w-1:0]          req_id_i;
  logic                     req_ready_o;
  logic                     chunk_v_o;
  logic [id_w-1:0]          chunk_id_o;
  logic [index_width_p-1:0] chunk_start_o;
  logic [index_width_p-1:0] chunk_end_o;
  logic                     chunk_empty_o;
  logic                     chunk_last_o;
  logic                     chunk_yumi_i;

  modport slave (
    input  cfg_v_i, cfg_w_i, cfg_addr_i, cfg_data_i, cfg_yumi_i,
    output cfg_ready_o, cfg_v_o, cfg_data_o,
    input  req_v_i, req_id_i, chunk_yumi_i,
    output req_ready_o, chunk_v_o, chunk_id_o,
    output chunk_start_o, chunk_end_o,
    output chunk_empty_o, chunk_last_o
  );

  modport master (
    output cfg_v_i, cfg_w_i, cfg_addr_i, cfg_data_i, cfg_yumi_i,
    input  cfg_ready_o, cfg_v_o, cfg_data_o,
    output req_v_i, req_id_i, chunk_yumi_i,
    input  req_ready_o, chunk_v_o, chunk_id_o,
    input  chunk_start_o, chunk_end_o,
    input  chunk_empty_o, chunk_last_o
  );
endinterface

// File: rtl/bp_mcore_looper.sv
// Hardware looper: config regs plus a shared cursor that splits [gstart,gend).
// Ports: clk_i, reset_n_i (async low), io (slave: cfg and chunk channels).
module bp_mcore_looper #(
  parameter int num_core_p    = 4,
  parameter int index_width_p = 64
) (
  input logic          clk_i,
  input logic          reset_n_i,
  bp_mcore_looper_if.slave io
);
  localparam int id_w = (num_core_p > 1) ? $clog2(num_core_p) : 1;
  localparam int iw   = index_width_p;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [19:0] A_CTRL   = 20'h00;
  localparam logic [19:0] A_GSTART = 20'h08;
  localparam logic [19:0] A_GEND   = 20'h10;
  localparam logic [19:0] A_LSTART = 20'h18;
  localparam logic [19:0] A_LEND   = 20'h20;

  logic [1:0]      state_q, state_d;
  logic [iw-1:0]   gstart_q, gend_q, cursor_q;
  logic [iw-1:0]   lstart_q, lend_q;
  logic [31:0]     chunk_q;

  logic            cfg_v_q;
  logic [63:0]     cfg_data_q;
  logic            ch_v_q;
  logic [id_w-1:0] ch_id_q;
  logic [iw-1:0]   ch_s_q, ch_e_q;
  logic            ch_empty_q, ch_last_q;

  assign io.cfg_ready_o   = ~cfg_v_q | io.cfg_yumi_i;
  assign io.cfg_v_o       = cfg_v_q;
  assign io.cfg_data_o    = cfg_data_q;
  assign io.req_ready_o   = ~ch_v_q | io.chunk_yumi_i;
  assign io.chunk_v_o     = ch_v_q;
  assign io.chunk_id_o    = ch_id_q;
  assign io.chunk_start_o = ch_s_q;
  assign io.chunk_end_o   = ch_e_q;
  assign io.chunk_empty_o = ch_empty_q;
  assign io.chunk_last_o  = ch_last_q;

  logic cfg_acc, req_acc, wr, run;
  logic wr_ctrl, go, abort, serve, has_work;

  assign cfg_acc  = io.cfg_v_i & io.cfg_ready_o;
  assign req_acc  = io.req_v_i & io.req_ready_o;
  assign wr       = cfg_acc & io.cfg_w_i;
  assign run      = (state_q == S_RUN);
  assign wr_ctrl  = wr & (io.cfg_addr_i == A_CTRL);
  assign go       = wr_ctrl & io.cfg_data_i[0];
  assign abort    = wr_ctrl & io.cfg_data_i[3];
  assign serve    = req_acc & run;
  assign has_work = (gstart_q < gend_q);

  // One extra bit on the sum so a chunk past 2^iw clamps to gend.
  logic [31:0]   csz;
  logic [iw:0]   sum;
  logic [iw-1:0] nxt_end;
  logic          is_last;

  assign csz     = (chunk_q == '0) ? 32'd1 : chunk_q;
  assign sum     = {1'b0, cursor_q} + (iw+1)'(csz);
  assign nxt_end = (sum >= {1'b0, gend_q}) ? gend_q
                                           : sum[iw-1:0];
  assign is_last = (nxt_end == gend_q);

  logic [63:0] rdata;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      io.cfg_addr_i == A_CTRL:
        rdata = {16'b0, chunk_q, 13'b0,
                 state_q == S_DONE, run, 1'b0};
      io.cfg_addr_i == A_GSTART: rdata = 64'(gstart_q);
      io.cfg_addr_i == A_GEND:   rdata = 64'(gend_q);
      io.cfg_addr_i == A_LSTART: rdata = 64'(lstart_q);
      io.cfg_addr_i == A_LEND:   rdata = 64'(lend_q);
      default:                   rdata = '0;
    endcase
  end

  // A last chunk served alongside ABORT still ends in DONE.
  always_comb begin
    state_d = state_q;
    if (run) begin
      if (serve & is_last) state_d = S_DONE;
      else if (abort)      state_d = S_IDLE;
    end else if (go) begin
      state_d = has_work ? S_RUN : S_DONE;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      gstart_q <= '0;
      gend_q   <= '0;
      cursor_q <= '0;
      lstart_q <= '0;
      lend_q   <= '0;
      chunk_q  <= '0;
    end else begin
      state_q <= state_d;
      if (wr & ~run) begin
        if (io.cfg_addr_i == A_GSTART)
          gstart_q <= io.cfg_data_i[iw-1:0];
        if (io.cfg_addr_i == A_GEND)
          gend_q <= io.cfg_data_i[iw-1:0];
        if (io.cfg_addr_i == A_CTRL)
          chunk_q <= io.cfg_data_i[47:16];
      end
      if (~run & go & has_work)
        cursor_q <= gstart_q;
      if (serve) begin
        cursor_q <= nxt_end;
        lstart_q <= cursor_q;
        lend_q   <= nxt_end;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cfg_v_q    <= 1'b0;
      cfg_data_q <= '0;
    end else if (cfg_acc) begin
      cfg_v_q    <= 1'b1;
      cfg_data_q <= io.cfg_w_i ? '0 : rdata;
    end else if (io.cfg_yumi_i) begin
      cfg_v_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ch_v_q     <= 1'b0;
      ch_id_q    <= '0;
      ch_s_q     <= '0;
      ch_e_q     <= '0;
      ch_empty_q <= 1'b0;
      ch_last_q  <= 1'b0;
    end else if (req_acc) begin
      ch_v_q  <= 1'b1;
      ch_id_q <= io.req_id_i;
      if (run) begin
        ch_s_q     <= cursor_q;
        ch_e_q     <= nxt_end;
        ch_empty_q <= 1'b0;
        ch_last_q  <= is_last;
      end else begin
        ch_s_q     <= gend_q;
        ch_e_q     <= gend_q;
        ch_empty_q <= 1'b1;
        ch_last_q  <= 1'b0;
      end
    end else if (io.chunk_yumi_i) begin
      ch_v_q <= 1'b0;
    end
  end
endmodule
